// File: rtl/dram_block_port.sv
// Block-level front end to the subblock-streaming DRAM: serialises write blocks into beats and
// reassembles read beats. Define DRAM_PORT_CHECK_EN to add the err_sticky protocol checker.
module dram_block_port #(
   parameter int unsigned ADDR_BITS  = 32,
   parameter int unsigned BLOCK_BITS = 512,
   parameter int unsigned SUBBLOCKS  = 4,
   parameter int unsigned SUB_LOG2   = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_we,
   input  logic [ADDR_BITS-1:0]             req_addr,
   input  logic [BLOCK_BITS-1:0]            req_wdata,
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [BLOCK_BITS-1:0]            resp_rdata,
   output logic                             wr_ack,
   output logic [ADDR_BITS-1:0]             mem_addr,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [SUB_LOG2-1:0]              mem_dinDstrobe,
   output logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_din,
   input  logic [SUB_LOG2-1:0]              mem_doutDstrobe,
   input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_dout,
   input  logic                             mem_dready,
   input  logic                             mem_accR,
   input  logic                             mem_accW
`ifdef DRAM_PORT_CHECK_EN
   ,
   output logic                             err_sticky
`endif
);

   localparam int unsigned W   = BLOCK_BITS / SUBBLOCKS;
   localparam int unsigned OFS = $clog2(BLOCK_BITS / 8);
   localparam logic [SUB_LOG2-1:0] LAST = SUB_LOG2'(SUBBLOCKS - 1);

   typedef enum logic [2:0] {
      StIdle, StWrWait, StWrBurst, StRdWait, StRdCollect, StRdResp
   } state_t;

   state_t                state;
   logic [SUB_LOG2-1:0]   beat;
   logic [SUB_LOG2-1:0]   beat_nxt;
   logic [BLOCK_BITS-1:0] wr_block;
   logic [ADDR_BITS-1:0]  aligned;

   always_comb begin
      aligned          = req_addr;
      aligned[OFS-1:0] = '0;
      beat_nxt         = beat + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= StIdle;
         beat           <= '0;
         wr_block       <= '0;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         wr_ack         <= 1'b0;
         mem_addr       <= '0;
         mem_en         <= 1'b0;
         mem_we         <= 1'b0;
         mem_dinDstrobe <= '0;
         mem_din        <= '0;
      end else begin
         wr_ack <= 1'b0;
         mem_en <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  mem_addr  <= aligned;
                  wr_block  <= req_wdata;
                  req_ready <= 1'b0;
                  state     <= req_we ? StWrWait : StRdWait;
               end
            end
            StWrWait: begin
               if (mem_accW) begin
                  state          <= StWrBurst;
                  beat           <= '0;
                  mem_we         <= 1'b1;
                  mem_dinDstrobe <= '0;
                  mem_din        <= wr_block[W-1:0];
               end
            end
            // beat is the index currently on mem_din; advance it every cycle without gaps
            StWrBurst: begin
               if (beat == LAST) begin
                  mem_we    <= 1'b0;
                  wr_ack    <= 1'b1;
                  req_ready <= 1'b1;
                  beat      <= '0;
                  state     <= StIdle;
               end else begin
                  beat           <= beat_nxt;
                  mem_dinDstrobe <= beat_nxt;
                  mem_din        <= wr_block[beat_nxt*W +: W];
               end
            end
            StRdWait: begin
               if (mem_accR) begin
                  mem_en <= 1'b1;
                  beat   <= '0;
                  state  <= StRdCollect;
               end
            end
            // beat counts captured beats here so the checker can verify strobe order
            StRdCollect: begin
               if (mem_dready) begin
                  resp_rdata[mem_doutDstrobe*W +: W] <= mem_dout;
                  beat <= beat_nxt;
                  if (mem_doutDstrobe == LAST) begin
                     resp_valid <= 1'b1;
                     state      <= StRdResp;
                  end
               end
            end
            StRdResp: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  beat       <= '0;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef DRAM_PORT_CHECK_EN
   logic chk_stray;
   logic chk_order;
   logic chk_accw;

   always_comb begin
      chk_stray = mem_dready && (state != StRdCollect);
      chk_order = mem_dready && (state == StRdCollect) && (mem_doutDstrobe != beat);
      chk_accw  = (state == StWrBurst) && !mem_accW;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
      end else if (!err_sticky && (chk_stray || chk_order || chk_accw)) begin
         err_sticky <= 1'b1;
`ifndef SYNTHESIS
         $display("%m: protocol check tripped at %0t (stray=%0b order=%0b accw=%0b)",
                  $time, chk_stray, chk_order, chk_accw);
`endif
      end
   end
`endif

endmodule

// File: tb/tb_dram_block_port.sv
// Scoreboard bench for dram_block_port: stimulus pushes expected beats/blocks, a monitor pops them.
module tb_dram_block_port;

   localparam int unsigned AB  = 32;
   localparam int unsigned BB  = 512;
   localparam int unsigned N   = 4;
   localparam int unsigned SL  = 2;
   localparam int unsigned W   = BB / N;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_we;
   logic [AB-1:0] req_addr;
   logic [BB-1:0] req_wdata;
   logic          resp_valid, resp_ready;
   logic [BB-1:0] resp_rdata;
   logic          wr_ack;
   logic [AB-1:0] mem_addr;
   logic          mem_en, mem_we;
   logic [SL-1:0] mem_dinDstrobe, mem_doutDstrobe;
   logic [W-1:0]  mem_din, mem_dout;
   logic          mem_dready, mem_accR, mem_accW;
`ifdef DRAM_PORT_CHECK_EN
   logic          err_sticky;
`endif

   always #5 clk = ~clk;

   dram_block_port #(
      .ADDR_BITS(AB), .BLOCK_BITS(BB), .SUBBLOCKS(N), .SUB_LOG2(SL)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
      .mem_dinDstrobe(mem_dinDstrobe), .mem_din(mem_din),
      .mem_doutDstrobe(mem_doutDstrobe), .mem_dout(mem_dout), .mem_dready(mem_dready),
      .mem_accR(mem_accR), .mem_accW(mem_accW)
`ifdef DRAM_PORT_CHECK_EN
      , .err_sticky(err_sticky)
`endif
   );

   typedef struct {
      logic [AB-1:0] addr;
      logic [SL-1:0] idx;
      logic [W-1:0]  data;
   } wbeat_t;

   wbeat_t        wq[$];
   logic [AB-1:0] ackq[$];
   logic [AB-1:0] enq[$];
   logic [BB-1:0] rq[$];

   int checks = 0;
   int errors = 0;
   logic stray = 1'b0;

   task automatic chk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected event, expected handled event", name);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_wr_ack"}, wr_ack, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_din"}, mem_din, 0);
      chk({tag, "_strobe"}, mem_dinDstrobe, 0);
      chk({tag, "_rdata"}, resp_rdata, 0);
   endtask

   // Offer a request and hold it until accepted; data is the write block or the expected read block.
   task automatic issue(input logic we, input logic [AB-1:0] addr, input logic [BB-1:0] data,
                        input logic [AB-1:0] exp_addr);
      int n = 0;
      wbeat_t b;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = we ? data : '0;
      if (we) begin
         for (int i = 0; i < N; i++) begin
            b.addr = exp_addr;
            b.idx  = SL'(i);
            b.data = data[i*W +: W];
            wq.push_back(b);
         end
         ackq.push_back(exp_addr);
      end else begin
         enq.push_back(exp_addr);
         rq.push_back(data);
      end
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) fail_now("req_accept_timeout");
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_ack();
      int n = 0;
      while (!wr_ack && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ack) fail_now("wr_ack_timeout");
   endtask

   task automatic read_resp();
      int n = 0;
      while (!resp_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) begin
         fail_now("resp_timeout");
         return;
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("resp_hold", resp_valid, 1);
         chk("req_blocked", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_drop", resp_valid, 0);
      chk("idle_ready", req_ready, 1);
   endtask

   // Memory model: stores write beats, answers a read with in-order beats 0..N-1 and some gaps.
   initial begin
      logic [W-1:0]  beats[logic [AB+SL-1:0]];
      logic [AB-1:0] rd_addr = '0;
      bit            rd_on = 0;
      int            rd_cyc = 0;
      int            rd_idx = 0;
      mem_dready      = 1'b0;
      mem_dout        = '0;
      mem_doutDstrobe = '0;
      forever begin
         @(negedge clk);
         mem_dready = 1'b0;
         if (reset) begin
            rd_on = 0;
         end else begin
            if (mem_we) beats[{mem_addr, mem_dinDstrobe}] = mem_din;
            if (stray) begin
               mem_dready      = 1'b1;
               mem_doutDstrobe = '0;
               stray           = 1'b0;
            end else if (rd_on) begin
               rd_cyc++;
               if (rd_cyc >= 2 && (rd_cyc % 3) != 1) begin
                  chk("rd_addr_stable", mem_addr, rd_addr);
                  mem_dready      = 1'b1;
                  mem_doutDstrobe = rd_idx[SL-1:0];
                  mem_dout = beats.exists({rd_addr, rd_idx[SL-1:0]}) ?
                             beats[{rd_addr, rd_idx[SL-1:0]}] : '0;
                  rd_idx++;
                  if (rd_idx == N) rd_on = 0;
               end
            end
            if (mem_en) begin
               rd_on   = 1;
               rd_cyc  = 0;
               rd_idx  = 0;
               rd_addr = mem_addr;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a beat, ack, read start or response.
   initial begin
      logic          prev_we = 1'b0;
      logic          prev_ack = 1'b0;
      logic          prev_en = 1'b0;
      logic [SL-1:0] prev_strb = '0;
      wbeat_t        e;
      logic [AB-1:0] a;
      logic [BB-1:0] d;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            prev_we  = 1'b0;
            prev_ack = 1'b0;
            prev_en  = 1'b0;
         end else begin
            if (mem_we) begin
               chk("we_en_excl", mem_en, 0);
               if (wq.size() == 0) begin
                  fail_now("unexpected_wr_beat");
               end else begin
                  e = wq.pop_front();
                  chk("wr_addr", mem_addr, e.addr);
                  chk("wr_strobe", mem_dinDstrobe, e.idx);
                  chk("wr_data", mem_din, e.data);
                  if (e.idx != 0) chk("wr_gapless", prev_we, 1);
               end
            end
            if (wr_ack) begin
               chk("ack_pulse", prev_ack, 0);
               chk("ack_after_last", {prev_we, prev_strb}, {1'b1, SL'(N - 1)});
               if (ackq.size() == 0) fail_now("unexpected_wr_ack");
               else begin
                  a = ackq.pop_front();
                  chk("ack_addr", mem_addr, a);
               end
            end
            if (prev_en) chk("en_pulse", mem_en, 0);
            if (mem_en) begin
               chk("en_we_excl", mem_we, 0);
               if (enq.size() == 0) fail_now("unexpected_mem_en");
               else begin
                  a = enq.pop_front();
                  chk("rd_addr", mem_addr, a);
               end
            end
            if (resp_valid && resp_ready) begin
               if (rq.size() == 0) fail_now("unexpected_resp");
               else begin
                  d = rq.pop_front();
                  chk("resp_rdata", resp_rdata, d);
               end
            end
            prev_we   = mem_we;
            prev_strb = mem_dinDstrobe;
            prev_ack  = wr_ack;
            prev_en   = mem_en;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BB-1:0] blk1, blk2, blk3;
      int cnt;
      blk1 = {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}};
      blk2 = {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
      blk3 = {{32{4'h9}}, {32{4'h8}}, {32{4'h7}}, {32{4'h6}}};
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0; mem_accR = 1'b1; mem_accW = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // 1: write burst
      issue(1'b1, 32'h0000_8040, blk1, 32'h0000_8040);
      wait_ack();

      // 2: read back, response held for three cycles
      issue(1'b0, 32'h0000_8040, blk1, 32'h0000_8040);
      read_resp();

      // 3: write stalled by accW=0, read queued behind it and accepted on the ack cycle
      mem_accW = 1'b0;
      issue(1'b1, 32'h0000_8040, blk2, 32'h0000_8040);
      fork
         issue(1'b0, 32'h0000_8040, blk2, 32'h0000_8040);
         begin
            cnt = 0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               if (mem_we) cnt++;
            end
            chk("accw_stall", cnt, 0);
            mem_accW = 1'b1;
         end
      join
      read_resp();

      // 4: unaligned address
      issue(1'b0, 32'h0000_807F, blk2, 32'h0000_8040);
      chk("align_addr", mem_addr, 32'h0000_8040);
      read_resp();

      // 5a: reset during write beat 2
      issue(1'b1, 32'h0000_9000, blk3, 32'h0000_9000);
      cnt = 0;
      while (!(mem_we && mem_dinDstrobe == 2'd2) && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("wr_beat2_seen", {mem_we, mem_dinDstrobe}, {1'b1, 2'd2});
      reset = 1'b1;
      wq.delete();
      ackq.delete();
      @(negedge clk);
      check_reset_outputs("rst_wr");
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (wr_ack || mem_we) cnt++;
      end
      chk("no_ack_after_rst", cnt, 0);

      // 5b: reset during read collection, then a clean read
      issue(1'b0, 32'h0000_8040, blk2, 32'h0000_8040);
      cnt = 0;
      while (!mem_en && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("rd_en_seen", mem_en, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      enq.delete();
      rq.delete();
      @(negedge clk);
      check_reset_outputs("rst_rd");
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (resp_valid) cnt++;
      end
      chk("no_resp_after_rst", cnt, 0);
      issue(1'b0, 32'h0000_8040, blk2, 32'h0000_8040);
      read_resp();

`ifdef DRAM_PORT_CHECK_EN
      // 6: stray dready in IDLE sets the sticky error
      chk("err_clear", err_sticky, 0);
      stray = 1'b1;
      repeat (3) @(negedge clk);
      chk("err_set", err_sticky, 1);
      repeat (5) @(negedge clk);
      chk("err_sticky", err_sticky, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("err_reset", err_sticky, 0);
      reset = 1'b0;
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty", wq.size() + ackq.size() + enq.size() + rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
